// File: rtl/envelope_voice.sv
// Four-phase attack/decay/sustain/release amplitude envelope that gates the
// 1-bit tone generator output into an 8-bit unsigned sample for the mixer.
module envelope_voice (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       wave_in,
  input  logic       gate,
  input  logic [7:0] data_in,
  input  logic       set_attack,
  input  logic       set_decay,
  input  logic       set_release,
  input  logic       set_sustain,
  output logic [7:0] sample_out,
  output logic [3:0] level,
  output logic       busy
);

  localparam int unsigned RATE_W  = 8;
  localparam int unsigned LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(15);

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } state_t;

  state_t              state;
  logic [RATE_W-1:0]   rc;
  logic                gate_q;
  logic [RATE_W-1:0]   attack_rate;
  logic [RATE_W-1:0]   decay_rate;
  logic [RATE_W-1:0]   release_rate;
  logic [LEVEL_W-1:0]  sustain_level;

  logic                gate_rise;
  logic                gate_fall;
  logic                held_note;
  logic                ramping;
  logic [LEVEL_W-1:0]  level_up;
  logic [LEVEL_W-1:0]  level_dn;

  assign gate_rise = gate & ~gate_q;
  assign gate_fall = ~gate & gate_q;
  assign held_note = (state == ATTACK) || (state == DECAY) || (state == SUSTAIN);
  assign ramping   = (state == ATTACK) || (state == DECAY) || (state == RELEASE);
  assign level_up  = level + LEVEL_W'(1);
  assign level_dn  = level - LEVEL_W'(1);

  // Gate edges take priority over ticks; rate writes land after any reload
  // on the same edge, so a reload always sees the pre-write rate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      level         <= '0;
      rc            <= '0;
      gate_q        <= 1'b0;
      attack_rate   <= '0;
      decay_rate    <= '0;
      release_rate  <= '0;
      sustain_level <= LEVEL_MAX;
      sample_out    <= '0;
      busy          <= 1'b0;
    end else begin
      gate_q     <= gate;
      sample_out <= wave_in ? {level, level} : 8'h00;

      if (set_attack)  attack_rate   <= data_in;
      if (set_decay)   decay_rate    <= data_in;
      if (set_release) release_rate  <= data_in;
      if (set_sustain) sustain_level <= data_in[LEVEL_W-1:0];

      if (gate_rise) begin
        state <= ATTACK;
        rc    <= attack_rate;
        busy  <= 1'b1;
      end else if (gate_fall && held_note) begin
        state <= RELEASE;
        rc    <= release_rate;
      end else if (tick && ramping) begin
        if (rc != '0) begin
          rc <= rc - RATE_W'(1);
        end else begin
          case (state)
            ATTACK: begin
              if (level != LEVEL_MAX) level <= level_up;
              if (level >= LEVEL_MAX - LEVEL_W'(1)) begin
                state <= DECAY;
                rc    <= decay_rate;
              end else begin
                rc <= attack_rate;
              end
            end
            DECAY: begin
              rc <= decay_rate;
              if (level <= sustain_level) begin
                state <= SUSTAIN;
              end else begin
                level <= level_dn;
                if (level_dn <= sustain_level) state <= SUSTAIN;
              end
            end
            RELEASE: begin
              rc <= release_rate;
              if (level != '0) level <= level_dn;
              if (level <= LEVEL_W'(1)) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_envelope_voice.sv
// Directed bench for envelope_voice: an integer envelope model checked every
// cycle, plus literal expectations at the scenario milestones.
module tb_envelope_voice;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       wave_in;
  logic       gate;
  logic [7:0] data_in;
  logic       set_attack;
  logic       set_decay;
  logic       set_release;
  logic       set_sustain;
  logic [7:0] sample_out;
  logic [3:0] level;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_wave = 1'b1;

  envelope_voice dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .wave_in     (wave_in),
    .gate        (gate),
    .data_in     (data_in),
    .set_attack  (set_attack),
    .set_decay   (set_decay),
    .set_release (set_release),
    .set_sustain (set_sustain),
    .sample_out  (sample_out),
    .level       (level),
    .busy        (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Envelope model: phase 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  int m_phase, m_level, m_wait, m_sample, m_gate_prev;
  int m_att, m_dec, m_rel, m_sus;

  function automatic int rate_for(int ph);
    if (ph == 1) return m_att;
    if (ph == 2) return m_dec;
    return m_rel;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_level = 0; m_wait = 0; m_sample = 0; m_gate_prev = 0;
      m_att = 0; m_dec = 0; m_rel = 0; m_sus = 15;
    end else begin
      m_sample = wave_in ? m_level * 17 : 0;
      if (gate && m_gate_prev == 0) begin
        m_phase = 1;
        m_wait  = m_att;
      end else if (!gate && m_gate_prev == 1 && m_phase >= 1 && m_phase <= 3) begin
        m_phase = 4;
        m_wait  = m_rel;
      end else if (tick && (m_phase == 1 || m_phase == 2 || m_phase == 4)) begin
        if (m_wait > 0) begin
          m_wait = m_wait - 1;
        end else begin
          m_wait = rate_for(m_phase);
          if (m_phase == 1) begin
            m_level = (m_level < 15) ? m_level + 1 : 15;
            if (m_level == 15) begin
              m_phase = 2;
              m_wait  = m_dec;
            end
          end else if (m_phase == 2) begin
            if (m_level > m_sus) m_level = m_level - 1;
            if (m_level <= m_sus) m_phase = 3;
          end else begin
            m_level = (m_level > 0) ? m_level - 1 : 0;
            if (m_level == 0) m_phase = 0;
          end
        end
      end
      if (set_attack)  m_att = int'(data_in);
      if (set_decay)   m_dec = int'(data_in);
      if (set_release) m_rel = int'(data_in);
      if (set_sustain) m_sus = int'(data_in[3:0]);
      m_gate_prev = gate ? 1 : 0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clock) begin
    chk("model_level", int'(level), m_level);
    chk("model_busy", int'(busy), (m_phase != 0) ? 1 : 0);
    chk("model_sample", int'(sample_out), m_sample);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
    if (rand_wave) wave_in = 1'($urandom_range(0, 1));
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  // sel: 0 attack, 1 decay, 2 release, 3 sustain
  task automatic wr(input int sel, input int val);
    data_in = 8'(val);
    set_attack  = (sel == 0);
    set_decay   = (sel == 1);
    set_release = (sel == 2);
    set_sustain = (sel == 3);
    cyc();
    set_attack = 0; set_decay = 0; set_release = 0; set_sustain = 0;
  endtask

  initial begin
    reset = 0; tick = 0; wave_in = 0; gate = 0; data_in = 0;
    set_attack = 0; set_decay = 0; set_release = 0; set_sustain = 0;
    #2 reset = 1;
    #1;
    chk("reset_level", int'(level), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_sample", int'(sample_out), 0);
    cyc();
    reset = 0;
    cyc();

    // attack 0, decay 1, sustain 8, release 3
    wr(0, 0); wr(1, 1); wr(3, 8); wr(2, 3);
    gate = 1; cyc();
    chk("attack_start", int'(level), 0);
    ticks(15);
    chk("attack_peak", int'(level), 15);
    ticks(14);
    chk("decay_to_sustain", int'(level), 8);
    ticks(3);
    chk("sustain_hold", int'(level), 8);
    chk("sustain_busy", int'(busy), 1);

    // release to 5, then retrigger
    gate = 0; cyc();
    ticks(12);
    chk("release_at5", int'(level), 5);
    gate = 1; cyc();
    chk("retrigger_keep", int'(level), 5);
    ticks(9);
    chk("retrigger_14", int'(level), 14);
    ticks(1);
    chk("retrigger_15", int'(level), 15);
    ticks(14);
    chk("decay_again", int'(level), 8);

    // fall on a tick cycle, then full release
    gate = 0; tick = 1; cyc(); tick = 0;
    chk("fall_tick_nochg", int'(level), 8);
    ticks(31);
    chk("release_31", int'(level), 1);
    chk("release_31_busy", int'(busy), 1);
    ticks(1);
    chk("release_done", int'(level), 0);
    chk("release_busy", int'(busy), 0);

    // sample path at level 10
    wr(3, 10);
    gate = 1; cyc();
    ticks(25);
    chk("level10", int'(level), 10);
    rand_wave = 0;
    wave_in = 1; cyc();
    chk("sample_aa", int'(sample_out), 8'hAA);
    wave_in = 0; cyc();
    chk("sample_00", int'(sample_out), 0);
    wave_in = 1; cyc();
    chk("sample_aa2", int'(sample_out), 8'hAA);
    rand_wave = 1;

    // attack-rate write colliding with a reload
    wr(2, 0);
    gate = 0; cyc();
    ticks(10);
    chk("fast_release", int'(level), 0);
    wr(0, 2);
    gate = 1; cyc();
    tick = 1; cyc(); cyc();
    data_in = 8'd9; set_attack = 1; cyc(); set_attack = 0;
    tick = 0;
    chk("coll_step1", int'(level), 1);
    ticks(2);
    chk("coll_wait", int'(level), 1);
    ticks(1);
    chk("coll_step2", int'(level), 2);
    ticks(9);
    chk("newrate_wait", int'(level), 2);
    ticks(1);
    chk("newrate_step3", int'(level), 3);
    ticks(10);
    chk("newrate_step4", int'(level), 4);
    ticks(30);
    chk("attack_at7", int'(level), 7);

    // asynchronous reset mid-attack
    rand_wave = 0; wave_in = 1;
    #2 reset = 1;
    #1;
    chk("async_level", int'(level), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_sample", int'(sample_out), 0);
    cyc();
    reset = 0;
    rand_wave = 1;
    cyc();
    chk("post_reset_rise", int'(busy), 1);
    chk("post_reset_level", int'(level), 0);
    ticks(15);
    ticks(5);
    chk("full_sustain15", int'(level), 15);
    chk("full_sustain_busy", int'(busy), 1);
    gate = 0; cyc();
    ticks(15);
    chk("final_idle", int'(busy), 0);
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
